// File: rtl/motor_arm_sequencer.sv
// motor_arm_sequencer
// Sequences the quadrotor motor stage through DISARMED, ARM_WAIT, SPINUP,
// FLY, SPINDOWN and KILL. It ramps a shared base duty toward the pilot
// throttle and generates four PWM outputs for the ESC pins. A motor whose
// trim bit is set gets a fixed extra duty while the craft is airborne.
// All status outputs are decoded from registered state only.

module motor_arm_sequencer #(
    parameter int PWM_BITS   = 8,
    parameter int ARM_HOLD   = 1000,
    parameter int RAMP_DIV   = 256,
    parameter int RAMP_STEP  = 1,
    parameter int IDLE_DUTY  = 32,
    parameter int TRIM_BOOST = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                arm_req,
    input  logic                level_ok,
    input  logic                gyro_fault,
    input  logic [PWM_BITS-1:0] throttle,
    input  logic [3:0]          trim,
    output logic [3:0]          pwm_out,
    output logic [PWM_BITS-1:0] base_duty,
    output logic [2:0]          state_o,
    output logic                takeoff,
    output logic                landing,
    output logic                fault_latched
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int HOLD_W  = (ARM_HOLD > 1) ? $clog2(ARM_HOLD) : 1;
    localparam int PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(ARM_HOLD - 1);
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(RAMP_DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;
    localparam logic [PWM_BITS-1:0] IDLE_D     = PWM_BITS'(IDLE_DUTY);
    localparam logic [PWM_BITS-1:0] STEP_D     = PWM_BITS'(RAMP_STEP);
    localparam logic [PWM_BITS:0]   BOOST_D    = (PWM_BITS + 1)'(TRIM_BOOST);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_ARM_WAIT = 3'd1,
        S_SPINUP   = 3'd2,
        S_FLY      = 3'd3,
        S_SPINDOWN = 3'd4,
        S_KILL     = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_next_state;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [PRESC_W-1:0]    r_presc;
    logic [PWM_BITS-1:0]   r_base_duty;
    logic [PWM_BITS-1:0]   w_base_next;
    logic [PWM_BITS-1:0]   r_pwm_cnt;
    logic [PWM_BITS-1:0]   r_dlat [4];
    logic [3:0]            r_pwm_out;

    logic                  w_tick;
    logic                  w_state_change;
    logic [PWM_BITS-1:0]   w_target;
    logic [PWM_BITS:0]     w_up_sum;
    logic [PWM_BITS-1:0]   w_ramp_up;
    logic [PWM_BITS-1:0]   w_ramp_dn_tgt;
    logic [PWM_BITS-1:0]   w_ramp_dn_zero;
    logic                  w_boost_en;
    logic                  w_pwm_en_next;
    logic [PWM_BITS:0]     w_duty_sum [4];
    logic [PWM_BITS-1:0]   w_duty [4];
    logic                  w_takeoff;
    logic                  w_landing;
    logic                  w_fault_latched;

    // ------------------------------------------------------------------
    // Ramp arithmetic
    // ------------------------------------------------------------------
    // Flight target never drops below the idle floor.
    assign w_target = (throttle > IDLE_D) ? throttle : IDLE_D;

    // One extra bit so base + step cannot wrap before the clamp.
    assign w_up_sum  = {1'b0, r_base_duty} + {1'b0, STEP_D};
    assign w_ramp_up = (w_up_sum >= {1'b0, w_target}) ? w_target
                                                        : w_up_sum[PWM_BITS-1:0];

    // Step down toward target without passing it.
    assign w_ramp_dn_tgt = ({1'b0, r_base_duty} >= ({1'b0, w_target} + {1'b0, STEP_D}))
                           ? (r_base_duty - STEP_D) : w_target;

    // Step down toward zero without wrapping.
    assign w_ramp_dn_zero = (r_base_duty >= STEP_D) ? (r_base_duty - STEP_D) : '0;

    assign w_tick         = (r_presc == PRESC_LAST);
    assign w_state_change = (w_next_state != r_state);

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    // Hold the current sequencer state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_DISARMED;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of block ordering.
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    // Choose the next state; gyro_fault outranks every other exit.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal
        // unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        case (r_state)
            S_DISARMED: begin
                if (arm_req && level_ok && !gyro_fault) begin
                    w_next_state = S_ARM_WAIT;
                end
            end
            S_ARM_WAIT: begin
                if (gyro_fault) begin
                    w_next_state = S_KILL;
                end else if (!arm_req || !level_ok) begin
                    w_next_state = S_DISARMED;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_next_state = S_SPINUP;
                end
            end
            S_SPINUP: begin
                if (gyro_fault) begin
                    w_next_state = S_KILL;
                end else if (!arm_req) begin
                    w_next_state = S_SPINDOWN;
                end else if (r_base_duty == w_target) begin
                    w_next_state = S_FLY;
                end
            end
            S_FLY: begin
                if (gyro_fault) begin
                    w_next_state = S_KILL;
                end else if (!arm_req) begin
                    w_next_state = S_SPINDOWN;
                end
            end
            S_SPINDOWN: begin
                // arm_req is deliberately ignored: spin-down always completes.
                if (gyro_fault) begin
                    w_next_state = S_KILL;
                end else if (r_base_duty == '0) begin
                    w_next_state = S_DISARMED;
                end
            end
            S_KILL: begin
                if (!arm_req && !gyro_fault) begin
                    w_next_state = S_DISARMED;
                end
            end
            default: begin
                w_next_state = S_DISARMED;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: output decode
    // ------------------------------------------------------------------
    // Decode status flags from the registered state only.
    always_comb begin
        w_takeoff       = (r_state == S_SPINUP) || (r_state == S_FLY);
        w_landing       = !w_takeoff;
        w_fault_latched = (r_state == S_KILL);
    end

    // ------------------------------------------------------------------
    // Arm hold counter and ramp prescaler
    // ------------------------------------------------------------------
    // Count cycles spent in ARM_WAIT; zero everywhere else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_cnt <= '0;
        end else if (r_state == S_ARM_WAIT) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end else begin
            r_hold_cnt <= '0;
        end
    end

    // Divide the clock into ramp ticks, restarting on every state entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
        end else if (w_state_change || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Base duty ramp
    // ------------------------------------------------------------------
    // Compute the next base duty from the current state and ramp tick.
    always_comb begin
        w_base_next = r_base_duty;
        case (r_state)
            S_SPINUP: begin
                if (w_tick) begin
                    w_base_next = w_ramp_up;
                end
            end
            S_FLY: begin
                if (w_tick) begin
                    if (r_base_duty < w_target) begin
                        w_base_next = w_ramp_up;
                    end else if (r_base_duty > w_target) begin
                        w_base_next = w_ramp_dn_tgt;
                    end
                end
            end
            S_SPINDOWN: begin
                if (w_tick) begin
                    w_base_next = w_ramp_dn_zero;
                end
            end
            default: begin
                w_base_next = '0;
            end
        endcase

        // Entry overrides: spin-up starts at idle, KILL/DISARMED hold zero.
        if ((w_next_state == S_KILL) || (w_next_state == S_DISARMED)) begin
            w_base_next = '0;
        end else if ((r_state == S_ARM_WAIT) && (w_next_state == S_SPINUP)) begin
            w_base_next = IDLE_D;
        end
    end

    // Register the base duty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_base_duty <= '0;
        end else begin
            r_base_duty <= w_base_next;
        end
    end

    // ------------------------------------------------------------------
    // PWM generation
    // ------------------------------------------------------------------
    assign w_boost_en    = (r_state == S_SPINUP) || (r_state == S_FLY);
    // Gate on the next state so pwm_out drops in the same cycle state_o
    // enters KILL or DISARMED, not at the end of the PWM period.
    assign w_pwm_en_next = (w_next_state == S_SPINUP) || (w_next_state == S_FLY) ||
                           (w_next_state == S_SPINDOWN);

    // Free-running PWM period counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
        end
    end

    // Per-motor duty: base plus optional trim boost, saturated at full scale.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_duty_sum[i] = {1'b0, r_base_duty} + ((trim[i] && w_boost_en) ? BOOST_D : '0);
            w_duty[i]     = w_duty_sum[i][PWM_BITS] ? DUTY_MAX : w_duty_sum[i][PWM_BITS-1:0];
        end
    end

    // Latch duties only at the period end so each PWM period is glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: this small duty bank is reset like ordinary flops so the
            // first PWM period after reset is defined; it is not a RAM.
            for (int i = 0; i < 4; i++) begin
                r_dlat[i] <= '0;
            end
        end else if (r_pwm_cnt == DUTY_MAX) begin
            for (int i = 0; i < 4; i++) begin
                r_dlat[i] <= w_duty[i];
            end
        end
    end

    // Registered PWM compare, forced low outside the motor-running states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pwm_out <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_pwm_out[i] <= w_pwm_en_next && (r_pwm_cnt < r_dlat[i]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pwm_out       = r_pwm_out;
    assign base_duty     = r_base_duty;
    assign state_o       = r_state;
    assign takeoff       = w_takeoff;
    assign landing       = w_landing;
    assign fault_latched = w_fault_latched;

endmodule

// File: tb/tb_motor_arm_sequencer.sv
// Directed self-checking bench for motor_arm_sequencer, using small
// parameters (ARM_HOLD=4, RAMP_DIV=2, RAMP_STEP=1, IDLE_DUTY=4, TRIM_BOOST=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_motor_arm_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       arm_req;
    logic       level_ok;
    logic       gyro_fault;
    logic [7:0] throttle;
    logic [3:0] trim;
    logic [3:0] pwm_out;
    logic [7:0] base_duty;
    logic [2:0] state_o;
    logic       takeoff;
    logic       landing;
    logic       fault_latched;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference PWM period counter: free-runs from zero after reset.
    logic [7:0] tb_pwm;

    motor_arm_sequencer #(
        .PWM_BITS  (8),
        .ARM_HOLD  (4),
        .RAMP_DIV  (2),
        .RAMP_STEP (1),
        .IDLE_DUTY (4),
        .TRIM_BOOST(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .arm_req      (arm_req),
        .level_ok     (level_ok),
        .gyro_fault   (gyro_fault),
        .throttle     (throttle),
        .trim         (trim),
        .pwm_out      (pwm_out),
        .base_duty    (base_duty),
        .state_o      (state_o),
        .takeoff      (takeoff),
        .landing      (landing),
        .fault_latched(fault_latched)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) tb_pwm <= 8'd0;
        else        tb_pwm <= tb_pwm + 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int guard;
    int hi_cnt [4];

    initial begin
        reset      = 1'b1;
        arm_req    = 1'b0;
        level_ok   = 1'b0;
        gyro_fault = 1'b0;
        throttle   = 8'd0;
        trim       = 4'b0000;
        #2 reset   = 1'b0;
        step(2);                                  // t=20

        // Reset state
        check("rst_state",   state_o,       0);
        check("rst_base",    base_duty,     0);
        check("rst_pwm",     pwm_out,       0);
        check("rst_takeoff", takeoff,       0);
        check("rst_landing", landing,       1);
        check("rst_fault",   fault_latched, 0);
        reset = 1'b1;

        // Arm abort: level_ok drops at hold_cnt=2
        arm_req  = 1'b1;
        level_ok = 1'b1;
        throttle = 8'd10;
        step(1);                                  // t=30
        check("abort_armwait", state_o, 1);
        step(2);                                  // t=50, hold_cnt=2
        level_ok = 1'b0;
        step(1);                                  // t=60
        check("abort_state", state_o,   0);
        check("abort_base",  base_duty, 0);

        // Arming and ramp to throttle=10
        level_ok = 1'b1;
        step(4);                                  // t=100, 4th ARM_WAIT cycle
        check("arm_wait_4", state_o, 1);
        step(1);                                  // t=110
        check("spinup_state", state_o,   2);
        check("spinup_idle",  base_duty, 4);
        check("spinup_tkoff", takeoff,   1);
        step(2);                                  // t=130
        check("ramp_first", base_duty, 5);
        step(10);                                 // t=230
        check("ramp_top",       base_duty, 10);
        check("ramp_top_state", state_o,   2);
        step(1);                                  // t=240
        check("fly_state",   state_o, 3);
        check("fly_takeoff", takeoff, 1);
        check("fly_landing", landing, 0);

        // Spin-down from base_duty=10, arm_req re-raised mid-way
        arm_req = 1'b0;
        step(1);                                  // t=250
        check("sd_state", state_o,   4);
        check("sd_base",  base_duty, 10);
        step(1);                                  // t=260
        arm_req = 1'b1;
        step(1);                                  // t=270
        check("sd_tick1",       base_duty, 9);
        check("sd_ignore_arm",  state_o,   4);
        step(17);                                 // t=440
        check("sd_base_1", base_duty, 1);
        step(1);                                  // t=450
        check("sd_base_0",     base_duty, 0);
        check("sd_still_down", state_o,   4);
        arm_req = 1'b0;
        step(1);                                  // t=460
        check("sd_disarmed", state_o, 0);
        check("sd_pwm_off",  pwm_out, 0);

        // Fault in SPINUP together with arm_req drop
        arm_req = 1'b1;
        step(5);                                  // t=510
        check("f_spinup", state_o, 2);
        gyro_fault = 1'b1;
        arm_req    = 1'b0;
        step(1);                                  // t=520
        check("f_kill",     state_o,       5);
        check("f_latched",  fault_latched, 1);
        check("f_pwm",      pwm_out,       0);
        check("f_base",     base_duty,     0);
        check("f_takeoff",  takeoff,       0);
        gyro_fault = 1'b0;
        arm_req    = 1'b1;
        step(3);                                  // t=550
        check("f_hold_arm",   state_o,       5);
        check("f_hold_latch", fault_latched, 1);
        arm_req    = 1'b0;
        gyro_fault = 1'b1;
        step(1);                                  // t=560
        check("f_hold_gyro", state_o, 5);
        gyro_fault = 1'b0;
        step(1);                                  // t=570
        check("f_exit",       state_o,       0);
        check("f_exit_latch", fault_latched, 0);

        // Saturation: base 250 with trim 0101
        arm_req  = 1'b1;
        throttle = 8'd250;
        trim     = 4'b0101;
        guard = 0;
        while (state_o != 3'd3 && guard < 1000) begin step(1); guard++; end
        check("sat_fly",  state_o,   3);
        check("sat_base", base_duty, 250);
        // Align to the first cycle of a fresh period with stable duties.
        guard = 0;
        do begin step(1); guard++; end while (tb_pwm != 8'd0 && guard < 300);
        step(1);
        for (int k = 0; k < 4; k++) hi_cnt[k] = 0;
        for (int c = 0; c < 256; c++) begin
            for (int k = 0; k < 4; k++) hi_cnt[k] += int'(pwm_out[k]);
            step(1);
        end
        check("sat_m1", hi_cnt[0], 255);
        check("sat_m2", hi_cnt[1], 250);
        check("sat_m3", hi_cnt[2], 255);
        check("sat_m4", hi_cnt[3], 250);

        // Trim change mid-period only takes effect at the wrap
        trim  = 4'b0000;
        guard = 0;
        while (tb_pwm != 8'd253 && guard < 300) begin step(1); guard++; end
        check("latch_hold", pwm_out, 4'b0101);
        step(1);
        guard = 0;
        while (tb_pwm != 8'd253 && guard < 300) begin step(1); guard++; end
        check("latch_new", pwm_out, 4'b0000);

        // Throttle drop below idle: descend to the IDLE_DUTY floor
        throttle = 8'd2;
        guard = 0;
        while (base_duty != 8'd4 && guard < 1200) begin step(1); guard++; end
        check("floor_reach", base_duty, 4);
        step(10);
        check("floor_hold",  base_duty, 4);
        check("floor_state", state_o,   3);

        // Reset mid-FLY while a PWM output is high
        guard = 0;
        while (pwm_out[0] != 1'b1 && guard < 600) begin step(1); guard++; end
        check("pre_rst_pwm", pwm_out[0], 1);
        reset = 1'b0;
        #1;
        check("midrst_pwm",     pwm_out,   0);
        check("midrst_base",    base_duty, 0);
        check("midrst_state",   state_o,   0);
        check("midrst_landing", landing,   1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/motor_arm_sequencer.md
Name: motor_arm_sequencer

Overview:
- Sequences the quadrotor motor stage through arming, spin-up, flight and spin-down, and generates the four motor PWM outputs.
- Consumes the pilot arm switch (receiver CH5), a level flag and per-motor tilt-correction bits from the attitude FSM.
- Ramps a shared base duty and adds a per-motor correction boost.
- Sits between the receiver/attitude logic and the ESC pins.

Parameters:
PWM_BITS, 8, width of PWM counter and duty values
ARM_HOLD, 1000, cycles arm_req and level_ok must both hold before spin-up
RAMP_DIV, 256, clock cycles per ramp tick
RAMP_STEP, 1, duty change per ramp tick
IDLE_DUTY, 32, base duty on entry to SPINUP; minimum flight duty
TRIM_BOOST, 16, duty added to a motor whose trim bit is set

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
arm_req  in  1  pilot arm switch (receiver CH5), synchronous to clk
level_ok  in  1  craft level (no X/Y tilt flags active)
gyro_fault  in  1  gyro check failure
throttle  in  PWM_BITS  requested base duty
trim  in  4  bit i = boost motor i+1
pwm_out  out  4  ESC PWM, bit i = motor i+1
base_duty  out  PWM_BITS  current ramped base duty
state_o  out  3  DISARMED=0, ARM_WAIT=1, SPINUP=2, FLY=3, SPINDOWN=4, KILL=5
takeoff  out  1  state is SPINUP or FLY
landing  out  1  equals !takeoff
fault_latched  out  1  set while in KILL

Behaviour:
- Reset (reset=0, async):
  - State goes to DISARMED.
  - hold_cnt, ramp prescaler, pwm_cnt, base_duty and the latched duties are cleared to 0.
  - Outputs: pwm_out=0, takeoff=0, landing=1, fault_latched=0.
  - Reset mid-flight kills the motors immediately.
- target = max(throttle, IDLE_DUTY).
- Ramp tick: the prescaler counts 0..RAMP_DIV-1, clears on every state entry, and pulses a tick on terminal count.
- DISARMED:
  - base_duty=0.
  - arm_req && level_ok && !gyro_fault -> ARM_WAIT with hold_cnt=0.
- ARM_WAIT:
  - hold_cnt increments each cycle.
  - If arm_req or level_ok drops -> DISARMED.
  - At hold_cnt==ARM_HOLD-1 with both still high -> SPINUP, base_duty<=IDLE_DUTY.
- SPINUP:
  - On each tick, base_duty<=min(base_duty+RAMP_STEP, target).
  - When base_duty==target -> FLY on the following cycle.
  - !arm_req -> SPINDOWN.
- FLY:
  - On each tick, base_duty moves toward target by at most RAMP_STEP, up or down, with no overshoot.
  - !arm_req -> SPINDOWN.
- SPINDOWN:
  - On each tick, base_duty<=max(base_duty-RAMP_STEP, 0).
  - At base_duty==0 -> DISARMED.
  - Re-assertion of arm_req is ignored; the spin-down always completes.
- KILL:
  - gyro_fault=1 in any state other than DISARMED -> KILL next edge.
  - On entry, base_duty<=0 and fault_latched<=1.
  - Leaves to DISARMED only when arm_req==0 && gyro_fault==0; fault_latched clears on that transition.
  - gyro_fault has priority over every other transition, including simultaneous arm_req drop.
- PWM generation:
  - pwm_cnt free-runs 0..2^PWM_BITS-1 and wraps to 0.
  - Per-motor duty_i = base_duty + (trim[i] && state in {SPINUP,FLY} ? TRIM_BOOST : 0), saturated at 2^PWM_BITS-1 (no wrap).
  - duty_i is latched into dlat_i only when pwm_cnt==2^PWM_BITS-1, giving glitch-free periods.
  - pwm_out[i] is registered: (pwm_cnt < dlat_i) when state in {SPINUP,FLY,SPINDOWN}, else 0.
  - duty 0 gives a constant-low output; duty 255 gives 255/256 high.
  - On entry to KILL or DISARMED, pwm_out is forced 0 from the cycle state_o changes, without waiting for the period end.
- takeoff, landing and fault_latched are decoded from the registered state, with no combinational input paths.

Test Plan (ARM_HOLD=4, RAMP_DIV=2, RAMP_STEP=1, IDLE_DUTY=4, TRIM_BOOST=16, PWM_BITS=8):
1. Assert reset=0 mid-FLY -> same cycle: pwm_out=0, base_duty=0, state_o=0, landing=1.
2. Arming and ramp:
   - Hold arm_req=1, level_ok=1, throttle=10 -> ARM_WAIT for 4 cycles, then SPINUP with base_duty=4.
   - base_duty then rises by 1 every 2 cycles up to 10; FLY follows one cycle later with takeoff=1.
3. Pulse level_ok=0 at hold_cnt=2 in ARM_WAIT -> state returns to DISARMED and base_duty stays 0.
4. Saturation and throttle tracking:
   - In FLY with base_duty=250 and trim=4'b0101 -> dlat for motors 1 and 3 = 255 (saturated), motors 2 and 4 = 250, updated only at the pwm_cnt wrap.
   - Drop throttle to 2 -> base_duty descends to 4 (IDLE_DUTY floor).
5. Spin-down:
   - Drop arm_req in FLY at base_duty=10 -> SPINDOWN, duty reaches 0 after 10 ticks (20 cycles), then DISARMED.
   - Re-raising arm_req during SPINDOWN has no effect.
6. Fault handling:
   - Assert gyro_fault in SPINUP together with an arm_req drop -> KILL, fault_latched=1, pwm_out=0.
   - Remains in KILL while arm_req=1; exits to DISARMED only when arm_req=0 && gyro_fault=0.
